debug_controller: RTL and testbench

- Debug sequencer between the debug UART and the MIPS pipeline inside the top-level MIPS wrapper.
- Loads a program into instruction memory from little-endian UART bytes, then waits for a command byte and runs the CPU continuously or single-steps it.
- After each run or step it dumps the CPU state back over the UART: PC, then register file, then data memory.

---
 rtl/debug_controller_if.sv | 40 ++++
 rtl/debug_controller.sv | 180 ++++++++++++++++++
 tb/tb_debug_controller.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_controller_if.sv
// Signal bundle between debug_controller and the UART / MIPS pipeline.
// master = controller side, slave = UART, memories and pipeline side.
interface debug_controller_if #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH_UART = 8,
  parameter int unsigned IMEM_ADDR_W     = 6
);
  logic                       i_rx_done;
  logic [DATA_WIDTH_UART-1:0] i_rx_data;
  logic                       i_tx_available;
  logic                       i_tx_done;
  logic                       o_tx_signal;
  logic [DATA_WIDTH_UART-1:0] o_tx_data;
  logic                       o_imem_we;
  logic [IMEM_ADDR_W-1:0]     o_imem_addr;
  logic [DATA_WIDTH-1:0]      o_imem_data;
  logic                       o_cpu_enable;
  logic                       i_cpu_halt;
  logic [DATA_WIDTH-1:0]      i_pc;
  logic [4:0]                 o_reg_addr;
  logic [DATA_WIDTH-1:0]      i_reg_data;
  logic [4:0]                 o_mem_addr;
  logic [DATA_WIDTH-1:0]      i_mem_data;
  logic                       o_load_overflow;
  logic [3:0]                 o_state;

  modport master (
    input  i_rx_done, i_rx_data, i_tx_available, i_tx_done, i_cpu_halt, i_pc, i_reg_data,
           i_mem_data,
    output o_tx_signal, o_tx_data, o_imem_we, o_imem_addr, o_imem_data, o_cpu_enable,
           o_reg_addr, o_mem_addr, o_load_overflow, o_state
  );

  modport slave (
    output i_rx_done, i_rx_data, i_tx_available, i_tx_done, i_cpu_halt, i_pc, i_reg_data,
           i_mem_data,
    input  o_tx_signal, o_tx_data, o_imem_we, o_imem_addr, o_imem_data, o_cpu_enable,
           o_reg_addr, o_mem_addr, o_load_overflow, o_state
  );
endinterface

// File: rtl/debug_controller.sv
// UART debug sequencer: program load, run/step control and PC/register/memory dump.
// Define DEBUG_STEP_EN to build the single-step command (0x01).
module debug_controller #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH_UART = 8,
  parameter int unsigned IMEM_ADDR_W     = 6,
  parameter int unsigned NREGS           = 32,
  parameter int unsigned NMEM            = 32,
  parameter logic [5:0]  HALT_OPCODE     = 6'b111111
) (
  input logic                i_clock,
  input logic                i_reset,
  debug_controller_if.master dbg
);
  localparam int unsigned BytesPerWord = DATA_WIDTH / DATA_WIDTH_UART;
  localparam int unsigned ByteCntW     = $clog2(BytesPerWord);
  localparam int unsigned IdxW         = 5;

  typedef enum logic [3:0] {
    StLoad    = 4'd0,
    StWaitCmd = 4'd1,
    StRun     = 4'd2,
`ifdef DEBUG_STEP_EN
    StStep    = 4'd3,
`endif
    StDumpPc  = 4'd4,
    StDumpReg = 4'd5,
    StDumpMem = 4'd6,
    StCapture = 4'd7,
    StSend    = 4'd8,
    StWaitTx  = 4'd9,
    StDone    = 4'd10,
    StImemWr  = 4'd11
  } state_e;

  typedef enum logic [1:0] {PhPc, PhReg, PhMem} phase_e;

  state_e                state_q, state_d;
  phase_e                phase_q;
  logic [DATA_WIDTH-1:0] word_q, tx_q;
  logic [ByteCntW-1:0]   byte_q;
  logic [IMEM_ADDR_W-1:0] addr_q;
  logic [IdxW-1:0]       idx_q;
  logic                  stop_q, overflow_q;
  logic                  last_byte, is_halt, addr_last, idx_last, cmd_run;

  assign last_byte = byte_q == ByteCntW'(BytesPerWord - 1);
  assign is_halt   = word_q[DATA_WIDTH-1 -: 6] == HALT_OPCODE;
  assign addr_last = &addr_q;
  assign idx_last  = (phase_q == PhReg) ? (idx_q == IdxW'(NREGS - 1)) :
                                          (idx_q == IdxW'(NMEM - 1));
  assign cmd_run   = dbg.i_rx_done && (dbg.i_rx_data == '0);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) state_q <= StLoad;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLoad:    if (dbg.i_rx_done && last_byte) state_d = StImemWr;
      StImemWr:  state_d = (is_halt || addr_last) ? StWaitCmd : StLoad;
      StWaitCmd: begin
        if (cmd_run) state_d = StRun;
`ifdef DEBUG_STEP_EN
        else if (dbg.i_rx_done && dbg.i_rx_data == DATA_WIDTH_UART'(1)) state_d = StStep;
`endif
      end
      StRun:     if (dbg.i_cpu_halt) state_d = StDumpPc;
`ifdef DEBUG_STEP_EN
      StStep:    state_d = StDumpPc;
`endif
      StDumpPc:  state_d = StSend;
      StDumpReg, StDumpMem: state_d = StCapture;
      StCapture: state_d = StSend;
      StSend:    if (dbg.i_tx_available) state_d = StWaitTx;
      StWaitTx: begin
        if (dbg.i_tx_done) begin
          if (!last_byte) begin
            state_d = StSend;
          end else begin
            unique case (phase_q)
              PhPc:    state_d = StDumpReg;
              PhReg:   state_d = idx_last ? StDumpMem : StDumpReg;
              default: state_d = !idx_last ? StDumpMem : (stop_q ? StDone : StWaitCmd);
            endcase
          end
        end
      end
      default:   state_d = state_q;
    endcase
  end

  // Datapath: word assembler, write address, dump index and transmit shifter.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      phase_q    <= PhPc;
      word_q     <= '0;
      tx_q       <= '0;
      byte_q     <= '0;
      addr_q     <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (dbg.i_rx_done) begin
            word_q <= {dbg.i_rx_data, word_q[DATA_WIDTH-1:DATA_WIDTH_UART]};
            byte_q <= byte_q + 1'b1;
          end
        end
        StImemWr: begin
          addr_q <= addr_q + 1'b1;
          if (!is_halt && addr_last) overflow_q <= 1'b1;
        end
        StWaitCmd: if (cmd_run) stop_q <= 1'b1;
`ifdef DEBUG_STEP_EN
        StStep:    stop_q <= dbg.i_cpu_halt;
`endif
        StDumpPc: begin
          tx_q    <= dbg.i_pc;
          byte_q  <= '0;
          phase_q <= PhPc;
          idx_q   <= '0;
        end
        StCapture: tx_q <= (phase_q == PhReg) ? dbg.i_reg_data : dbg.i_mem_data;
        StWaitTx: begin
          if (dbg.i_tx_done) begin
            tx_q   <= tx_q >> DATA_WIDTH_UART;
            byte_q <= byte_q + 1'b1;
            if (last_byte) begin
              unique case (phase_q)
                PhPc: begin
                  phase_q <= PhReg;
                  idx_q   <= '0;
                end
                PhReg: begin
                  if (idx_last) begin
                    phase_q <= PhMem;
                    idx_q   <= '0;
                  end else begin
                    idx_q <= idx_q + 1'b1;
                  end
                end
                default: if (!idx_last) idx_q <= idx_q + 1'b1;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dbg.o_imem_we    = 1'b0;
    dbg.o_cpu_enable = 1'b0;
    dbg.o_tx_signal  = 1'b0;
    unique case (state_q)
      StImemWr: dbg.o_imem_we = 1'b1;
      // Enable drops in the very cycle halt is seen.
      StRun:    dbg.o_cpu_enable = !dbg.i_cpu_halt;
`ifdef DEBUG_STEP_EN
      StStep:   dbg.o_cpu_enable = 1'b1;
`endif
      StSend:   dbg.o_tx_signal = dbg.i_tx_available;
      default:  ;
    endcase
  end

  assign dbg.o_tx_data       = tx_q[DATA_WIDTH_UART-1:0];
  assign dbg.o_imem_addr     = addr_q;
  assign dbg.o_imem_data     = word_q;
  assign dbg.o_reg_addr      = (phase_q == PhReg) ? idx_q : '0;
  assign dbg.o_mem_addr      = (phase_q == PhMem) ? idx_q : '0;
  assign dbg.o_load_overflow = overflow_q;
  assign dbg.o_state         = state_q;
endmodule

// File: tb/tb_debug_controller.sv
// Self-checking bench for debug_controller: queue-based model of loads and dumps,
// UART/register/memory/halt responders and directed command sequences.
module tb_debug_controller;
  localparam logic [3:0] SLoad = 4'd0, SWaitCmd = 4'd1, SDone = 4'd10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  debug_controller_if dif ();

  debug_controller dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .dbg     (dif)
  );

  int nchecks = 0;
  int nerrors = 0;

  logic [7:0]  exp_tx[$];
  logic [37:0] exp_wr[$];
  logic [7:0]  tx_log[$];
  logic [31:0] load_words[$];
  int          en_cycles = 0;
  int          wr_count = 0;
  logic [5:0]  last_wr_addr;
  logic [31:0] last_wr_data;
  bit          halt_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: words are written at consecutive addresses until a HALT word or the last slot.
  task automatic model_load();
    for (int i = 0; i < load_words.size(); i++) begin
      exp_wr.push_back({6'(i), load_words[i]});
      if (load_words[i][31:26] == 6'b111111 || i == 63) break;
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_tx.push_back(w[8*b +: 8]);
  endtask

  // Model: PC, then registers (A5000000+n), then memory (12340000+n), each LSB first.
  task automatic model_dump(input logic [31:0] pc);
    push_word(pc);
    for (int n = 0; n < 32; n++) push_word(32'hA500_0000 + 32'(n));
    for (int n = 0; n < 32; n++) push_word(32'h1234_0000 + 32'(n));
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    dif.i_rx_data = b;
    dif.i_rx_done = 1'b1;
    @(negedge clk);
    dif.i_rx_done = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_load();
    model_load();
    for (int i = 0; i < load_words.size(); i++)
      for (int b = 0; b < 4; b++) send_byte(load_words[i][8*b +: 8]);
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string name);
    int k = 0;
    while (dif.o_state !== s && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(name, dif.o_state, s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Compare process: imem writes and transmitted bytes against the model queues.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (dif.o_cpu_enable) en_cycles++;
        if (dif.o_imem_we) begin
          check("imem write expected", 32'(exp_wr.size() > 0), 1);
          if (exp_wr.size() > 0) begin
            logic [37:0] e;
            e = exp_wr.pop_front();
            check("imem addr", 32'(dif.o_imem_addr), 32'(e[37:32]));
            check("imem data", dif.o_imem_data, e[31:0]);
          end
          wr_count++;
          last_wr_addr = dif.o_imem_addr;
          last_wr_data = dif.o_imem_data;
        end
        if (dif.o_tx_signal) begin
          check("tx strobe only when available", 32'(dif.i_tx_available), 1);
          check("tx byte expected", 32'(exp_tx.size() > 0), 1);
          if (exp_tx.size() > 0) check("tx byte", 32'(dif.o_tx_data), 32'(exp_tx.pop_front()));
          tx_log.push_back(dif.o_tx_data);
        end
      end
    end
  end

  // UART transmitter: busy after a strobe, done pulse, then idle a little later.
  initial begin
    logic [7:0] held;
    dif.i_tx_available = 1'b1;
    dif.i_tx_done      = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && dif.o_tx_signal) begin
        held = dif.o_tx_data;
        @(posedge clk);
        #1 dif.i_tx_available = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (rst_n) check("tx data held", 32'(dif.o_tx_data), 32'(held));
        end
        dif.i_tx_done = 1'b1;
        @(negedge clk);
        dif.i_tx_done = 1'b0;
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 dif.i_tx_available = 1'b1;
      end
    end
  end

  // Register file / data memory with one-cycle synchronous read.
  initial begin
    logic [4:0] ra, ma;
    dif.i_reg_data = '0;
    dif.i_mem_data = '0;
    forever begin
      @(negedge clk);
      ra = dif.o_reg_addr;
      ma = dif.o_mem_addr;
      @(posedge clk);
      #1;
      dif.i_reg_data = 32'hA500_0000 + 32'(ra);
      dif.i_mem_data = 32'h1234_0000 + 32'(ma);
    end
  end

  // CPU: HALT reaches writeback after 20 enabled cycles.
  initial begin
    dif.i_cpu_halt = 1'b0;
    forever begin
      @(posedge clk);
      #1 dif.i_cpu_halt = halt_en && (en_cycles >= 20);
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    dif.i_rx_done = 1'b0;
    dif.i_rx_data = '0;
    dif.i_pc      = '0;
    repeat (3) @(negedge clk);

    check("reset state", 32'(dif.o_state), 32'(SLoad));
    check("reset strobes", 32'({dif.o_imem_we, dif.o_cpu_enable, dif.o_tx_signal,
                                dif.o_load_overflow}), 0);
    check("reset tx data", 32'(dif.o_tx_data), 0);
    check("reset imem addr", 32'(dif.o_imem_addr), 0);
    rst_n = 1'b1;

    // Load with HALT as the 8th word; the 9th word's bytes land in WAIT_CMD and are ignored.
    for (int i = 0; i < 9; i++)
      load_words.push_back(i == 7 ? 32'hFC00_0000 : 32'h2000_0000 + 32'(i) * 32'h0001_0101);
    send_load();
    repeat (5) @(negedge clk);
    check("load state", 32'(dif.o_state), 32'(SWaitCmd));
    check("load writes pending", 32'(exp_wr.size()), 0);
    check("load write count", 32'(wr_count), 8);
    check("halt write addr", 32'(last_wr_addr), 7);
    check("halt write data", last_wr_data, 32'hFC00_0000);
    check("no overflow", 32'(dif.o_load_overflow), 0);

    // RUN: halt after 20 cycles, full dump, DONE.
    dif.i_pc = 32'h1C;
    halt_en = 1'b1;
    en_cycles = 0;
    tx_log.delete();
    model_dump(32'h1C);
    send_byte(8'h00);
    wait_state(SDone, 6000, "run reaches done");
    check("run enable cycles", 32'(en_cycles), 20);
    check("run dump length", 32'(tx_log.size()), 260);
    check("dump pending", 32'(exp_tx.size()), 0);
    if (tx_log.size() == 260) begin
      check("pc byte0", 32'(tx_log[0]), 32'h1C);
      check("pc byte1", 32'(tx_log[1]), 32'h00);
      check("pc byte3", 32'(tx_log[3]), 32'h00);
      check("reg3 byte0", 32'(tx_log[16]), 32'h03);
      check("reg3 byte1", 32'(tx_log[17]), 32'h00);
      check("reg3 byte3", 32'(tx_log[19]), 32'hA5);
      check("mem0 byte2", 32'(tx_log[134]), 32'h34);
      check("last byte", 32'(tx_log[259]), 32'h12);
    end
    send_byte(8'h00);
    repeat (30) @(negedge clk);
    check("done ignores input", 32'(dif.o_state), 32'(SDone));
    check("done no enable", 32'(en_cycles), 20);

    // Overflow: 64 words, no HALT.
    halt_en = 1'b0;
    do_reset();
    wr_count = 0;
    load_words.delete();
    for (int i = 0; i < 64; i++) load_words.push_back(32'h0400_0000 + 32'(i));
    send_load();
    repeat (5) @(negedge clk);
    check("overflow flag", 32'(dif.o_load_overflow), 1);
    check("overflow state", 32'(dif.o_state), 32'(SWaitCmd));
    check("overflow write count", 32'(wr_count), 64);
    check("overflow last addr", 32'(last_wr_addr), 63);
    en_cycles = 0;
    tx_log.delete();
    send_byte(8'h07);
    repeat (20) @(negedge clk);
    check("unknown cmd state", 32'(dif.o_state), 32'(SWaitCmd));
    check("unknown cmd enable", 32'(en_cycles), 0);
    check("unknown cmd tx", 32'(tx_log.size()), 0);

`ifdef DEBUG_STEP_EN
    for (int s = 0; s < 3; s++) begin
      dif.i_pc = 32'h40 + 32'(s) * 4;
      tx_log.delete();
      model_dump(dif.i_pc);
      send_byte(8'h01);
      wait_state(SWaitCmd, 6000, "step returns to wait");
      check("step enable cycles", 32'(en_cycles), 32'(s + 1));
      check("step dump length", 32'(tx_log.size()), 260);
    end
`else
    send_byte(8'h01);
    repeat (20) @(negedge clk);
    check("step cmd ignored state", 32'(dif.o_state), 32'(SWaitCmd));
    check("step cmd ignored enable", 32'(en_cycles), 0);
    check("step cmd ignored tx", 32'(tx_log.size()), 0);
`endif

    // Reset during register dump byte 2, then reload from address 0.
    dif.i_pc = 32'h1C;
    halt_en = 1'b1;
    en_cycles = 0;
    tx_log.delete();
    model_dump(32'h1C);
    send_byte(8'h00);
    k = 0;
    while (tx_log.size() < 6 && k < 4000) begin
      @(negedge clk);
      k++;
    end
    check("reached reg byte 2", 32'(tx_log.size()), 6);
    #2 rst_n = 1'b0;
    #1;
    check("async reset state", 32'(dif.o_state), 32'(SLoad));
    check("async reset strobes", 32'({dif.o_imem_we, dif.o_cpu_enable, dif.o_tx_signal,
                                      dif.o_load_overflow}), 0);
    check("async reset tx data", 32'(dif.o_tx_data), 0);
    check("async reset imem data", dif.o_imem_data, 0);
    check("async reset addrs", 32'({dif.o_reg_addr, dif.o_mem_addr}), 0);
    exp_tx.delete();
    halt_en = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    check("post reset state", 32'(dif.o_state), 32'(SLoad));
    wr_count = 0;
    load_words.delete();
    load_words.push_back(32'h2400_0005);
    load_words.push_back(32'hFC00_0000);
    send_load();
    repeat (5) @(negedge clk);
    check("reload state", 32'(dif.o_state), 32'(SWaitCmd));
    check("reload write count", 32'(wr_count), 2);
    check("reload last addr", 32'(last_wr_addr), 1);
    check("reload writes pending", 32'(exp_wr.size()), 0);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end
endmodule
